clk_rst_gen: RTL

Parametrised clock-enable and reset generator that sits between the board pins (fast `clk`, pushbutton reset) and `core`. It generalises the fixed counter-tap divider and 3-flop reset shift into NUM_CH run-time-programmable divider channels. It also sequences reset: synchronised deassertion, then a hold period measured in ticks of channel 0, so `core` sees clock edges while still in reset.

---
 rtl/clk_rst_pkg.sv | 13 +
 rtl/clk_rst_gen_if.sv | 25 ++
 rtl/clk_div_ch.sv | 55 +++++
 rtl/clk_rst_gen.sv | 79 +++++++
 4 files changed

// File: rtl/clk_rst_pkg.sv
// Shared types and defaults for the clock-enable / reset generator.
package clk_rst_pkg;

    typedef enum logic [1:0] {
        RESET = 2'd0,
        SYNC  = 2'd1,
        HOLD  = 2'd2,
        RUN   = 2'd3
    } state_t;

    localparam int DIV_W_DEF = 24;

endpackage

// File: rtl/clk_rst_gen_if.sv
// Divisor programming inputs and reset/enable outputs of clk_rst_gen.
interface clk_rst_gen_if
    import clk_rst_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int DIV_W  = DIV_W_DEF
);
    logic [NUM_CH*DIV_W-1:0] div_in;
    logic [NUM_CH-1:0]       div_load;
    logic                    core_rst_n;
    logic                    rst_active;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       clk_div;

    // master: the generator itself; slave: whoever programs it and consumes the enables
    modport master (
        input  div_in, div_load,
        output core_rst_n, rst_active, tick, clk_div
    );

    modport slave (
        output div_in, div_load,
        input  core_rst_n, rst_active, tick, clk_div
    );
endinterface

// File: rtl/clk_div_ch.sv
// One programmable divider channel: tick pulse every D+1 clocks, clk_div toggles per tick.
module clk_div_ch #(
    parameter int DIV_W       = 24,
    parameter int DEFAULT_DIV = 131071
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             load,
    output logic             tick,
    output logic             clk_div
);
    localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] cnt, d, shadow;
    logic             pending;
    logic             wrap;

    assign wrap = en && (cnt == d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            d       <= DEF;
            shadow  <= DEF;
            pending <= 1'b0;
            tick    <= 1'b0;
            clk_div <= 1'b0;
        end else begin
            // a load landing on the wrap edge is consumed there, so nothing stays pending
            if (load) begin
                shadow  <= div_in;
                pending <= !wrap;
            end else if (wrap) begin
                pending <= 1'b0;
            end

            if (!en) begin
                cnt  <= '0;
                tick <= 1'b0;
            end else if (wrap) begin
                cnt     <= '0;
                tick    <= 1'b1;
                clk_div <= ~clk_div;
                if (load)         d <= div_in;
                else if (pending) d <= shadow;
            end else begin
                cnt  <= cnt + 1'b1;
                tick <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clk_rst_gen.sv
// Reset synchroniser + RESET/SYNC/HOLD/RUN sequencer feeding NUM_CH divider channels;
// core reset is held for HOLD_TICKS channel-0 ticks so core sees enables while in reset.
module clk_rst_gen
    import clk_rst_pkg::*;
#(
    parameter int SYNC_STAGES = 3,
    parameter int HOLD_TICKS  = 4,
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = DIV_W_DEF,
    parameter int DEFAULT_DIV = 131071
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_rst_gen_if.master bus
);
    localparam int HW = $clog2(HOLD_TICKS + 1);

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [HW-1:0]          hold_cnt;
    logic                   core_rst_q;
    logic                   ch_en;
    logic [NUM_CH-1:0]      tick, clk_div;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESET;
            hold_cnt   <= '0;
            core_rst_q <= 1'b0;
        end else begin
            state      <= state_nx;
            core_rst_q <= (state_nx == RUN);
            if (state == HOLD && tick[0]) hold_cnt <= hold_cnt + 1'b1;
        end
    end

    // SYNC leaves on the edge that loads the last sync stage, hence the look at sync_d
    always_comb begin
        state_nx = state;
        case (state)
            RESET: state_nx = SYNC;
            SYNC:  if (sync_d[SYNC_STAGES-1]) state_nx = HOLD;
            HOLD:  if (sync_q[SYNC_STAGES-1] && tick[0] &&
                       hold_cnt == HW'(HOLD_TICKS - 1)) state_nx = RUN;
            RUN:   state_nx = RUN;
            default: state_nx = RESET;
        endcase
    end

    assign ch_en = (state == HOLD) || (state == RUN);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (ch_en),
            .div_in  (bus.div_in[i*DIV_W +: DIV_W]),
            .load    (bus.div_load[i]),
            .tick    (tick[i]),
            .clk_div (clk_div[i])
        );
    end

    assign bus.tick       = tick;
    assign bus.clk_div    = clk_div;
    assign bus.core_rst_n = core_rst_q;
    assign bus.rst_active = (state != RUN);

endmodule
